// File: rtl/fsm_pkg.sv
// Shared definitions for the menu-selection FSMs:
// state width, state encodings and the reset/idle state.
package fsm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'b000,
        WELCOME = 3'b001,
        SELECT  = 3'b010,
        OPT0    = 3'b011,
        OPT1    = 3'b100,
        OPT2    = 3'b101,
        OPT3    = 3'b110
    } menu_state_e;

    localparam logic [STATE_W-1:0] STATE_RESET = IDLE;

endpackage

// File: rtl/d_flip_flop_3bits.sv
// D-type state register for the menu FSMs.
// Async active-high reset; q is driven only from flops.
module d_flip_flop_3bits
    import fsm_pkg::*;
#(
    parameter int                WIDTH       = STATE_W,
    parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Next value is d unchanged; the FSM holds state by feeding q back.
    always_comb begin
        q_d = d;
    end

    // Capture on every rising clk; reset overrides asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_d_flip_flop_3bits.sv
// Self-checking bench for d_flip_flop_3bits:
// directed scenarios followed by random stimulus against a model.
module tb_d_flip_flop_3bits;

    logic [2:0] d;
    logic       clk;
    logic       reset;
    logic [2:0] q;

    logic [4:0] d5;
    logic       reset5;
    logic [4:0] q5;

    int n_tests;
    int n_fail;
    int model_q;

    d_flip_flop_3bits dut (
        .d     (d),
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    d_flip_flop_3bits #(
        .WIDTH       (5),
        .RESET_VALUE (5'b10101)
    ) dut5 (
        .d     (d5),
        .clk   (clk),
        .reset (reset5),
        .q     (q5)
    );

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // One full clock period; returns with clk low, 5 after the edge.
    task automatic tick();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk     = 1'b0;
        reset   = 1'b0;
        reset5  = 1'b0;
        d       = 3'b000;
        d5      = 5'b00000;

        // reset from unknown, clock idle
        #3;
        reset  = 1'b1;
        reset5 = 1'b1;
        #1;
        chk("reset_async", 8'(q), 8'h0);
        chk("reset_w5", 8'(q5), 8'h15);
        d = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_hold", 8'(q), 8'h0);
        end

        // release, then capture sequence
        reset = 1'b0;
        #2;
        chk("release_nochg", 8'(q), 8'h0);
        d = 3'b001; tick(); chk("cap1", 8'(q), 8'h1);
        d = 3'b010; tick(); chk("cap2", 8'(q), 8'h2);
        d = 3'b101; tick(); chk("cap3", 8'(q), 8'h5);
        d = 3'b110; tick(); chk("cap4", 8'(q), 8'h6);

        // mid-cycle stability
        d = 3'b010; tick(); chk("stab_pre", 8'(q), 8'h2);
        #1 d = 3'b011; #1 chk("stab_a", 8'(q), 8'h2);
        #1 d = 3'b100; #1 chk("stab_b", 8'(q), 8'h2);
        #1 d = 3'b111; #1 chk("stab_c", 8'(q), 8'h2);
        tick();
        chk("stab_post", 8'(q), 8'h7);

        // async reset mid-operation
        d = 3'b101; tick(); chk("mid_pre", 8'(q), 8'h5);
        #1 reset = 1'b1;
        #1 chk("mid_rst", 8'(q), 8'h0);
        #1 reset = 1'b0;
        #1 chk("mid_rel", 8'(q), 8'h0);
        d = 3'b011; tick(); chk("mid_next", 8'(q), 8'h3);

        // reset/clock collision
        d = 3'b110;
        #5;
        reset = 1'b1;
        clk   = 1'b1;
        #1 chk("coll", 8'(q), 8'h0);
        #2 reset = 1'b0;
        #2 clk = 1'b0;
        #1 chk("coll_rel", 8'(q), 8'h0);
        tick();
        chk("coll_next", 8'(q), 8'h6);

        // 5-bit instance
        chk("w5_held", 8'(q5), 8'h15);
        reset5 = 1'b0;
        d5 = 5'b01010;
        tick();
        chk("w5_cap", 8'(q5), 8'h0A);

        // random: model q is the last d seen at an edge
        // while reset was low, or 0 after any reset
        model_q = q;
        for (int i = 0; i < 300; i++) begin
            logic hold_rst;
            d = 3'($urandom_range(0, 7));
            hold_rst = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) begin
                #1 reset = 1'b1;
                model_q = 0;
                #1 chk("rnd_pulse", 8'(q), 8'(model_q));
                reset = 1'b0;
            end
            reset = hold_rst;
            if (hold_rst) model_q = 0;
            #1 chk("rnd_between", 8'(q), 8'(model_q));
            d = 3'($urandom_range(0, 7));
            tick();
            if (!hold_rst) model_q = d;
            chk("rnd_edge", 8'(q), 8'(model_q));
            reset = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
